// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit core control path.
// Contents: opcodes, FSM state codes, and the PC / write-back select codes.
package cpu_pkg;

   localparam int OPW = 4;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_AND = 4'h2;
   localparam logic [3:0] OP_OR  = 4'h3;
   localparam logic [3:0] OP_XOR = 4'h4;
   localparam logic [3:0] OP_NOT = 4'h5;
   localparam logic [3:0] OP_SHL = 4'h6;
   localparam logic [3:0] OP_SHR = 4'h7;
   localparam logic [3:0] OP_LI  = 4'h8;
   localparam logic [3:0] OP_LW  = 4'h9;
   localparam logic [3:0] OP_SW  = 4'hA;
   localparam logic [3:0] OP_BIZ = 4'hB;
   localparam logic [3:0] OP_BNZ = 4'hC;
   localparam logic [3:0] OP_JAL = 4'hD;
   localparam logic [3:0] OP_JMP = 4'hE;
   localparam logic [3:0] OP_JR  = 4'hF;

   localparam logic [3:0] FUNC_EOE = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6,
      ST_FAULT  = 3'd7
   } state_t;

   localparam logic [1:0] PC_SEL_INC = 2'd0;
   localparam logic [1:0] PC_SEL_IMM = 2'd1;
   localparam logic [1:0] PC_SEL_REG = 2'd2;

   localparam logic [1:0] WB_SEL_ALU = 2'd0;
   localparam logic [1:0] WB_SEL_IMM = 2'd1;
   localparam logic [1:0] WB_SEL_MEM = 2'd2;
   localparam logic [1:0] WB_SEL_PC1 = 2'd3;

   function automatic logic is_alu_op(input logic [3:0] op);
      return ~op[3];
   endfunction

endpackage

// File: rtl/ctrl_fsm_if.sv
// Handshake and strobe bundle between ctrl_fsm and the datapath / memories.
// CTRL_PERF_EN adds the retired and cycles counter outputs.
interface ctrl_fsm_if #(parameter int OPW = cpu_pkg::OPW);

   logic           start;
   logic [OPW-1:0] opcode;
   logic [OPW-1:0] func;
   logic           zero;
   logic           imem_ready;
   logic           dmem_ready;

   logic           imem_req;
   logic           ir_load;
   logic           pc_we;
   logic [1:0]     pc_sel;
   logic [OPW-1:0] alu_op;
   logic           reg_we;
   logic [1:0]     wb_sel;
   logic           dmem_re;
   logic           dmem_we;
   logic           halted;
   logic           fault;
   logic [2:0]     state;
`ifdef CTRL_PERF_EN
   logic [15:0]    retired;
   logic [15:0]    cycles;
`endif

   modport slave (
      input  start, opcode, func, zero, imem_ready, dmem_ready,
      output imem_req, ir_load, pc_we, pc_sel, alu_op, reg_we, wb_sel,
             dmem_re, dmem_we, halted, fault, state
`ifdef CTRL_PERF_EN
      , retired, cycles
`endif
   );

   modport master (
      output start, opcode, func, zero, imem_ready, dmem_ready,
      input  imem_req, ir_load, pc_we, pc_sel, alu_op, reg_we, wb_sel,
             dmem_re, dmem_we, halted, fault, state
`ifdef CTRL_PERF_EN
      , retired, cycles
`endif
   );

endinterface

// File: rtl/ctrl_wait_timer.sv
// Ready-handshake wait counter shared by FETCH and MEM.
// o_timeout flags the last allowed wait cycle while ready is still low.
module ctrl_wait_timer
   import cpu_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   input  logic i_ready,
   output logic o_timeout
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !i_ready && !o_timeout) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_timeout = i_en && !i_ready && (r_cnt == LAST);

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle control unit for the 16-bit core: fetch/decode/exec/mem/wb sequencing.
// CTRL_PERF_EN adds retired-instruction and active-cycle counters.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | imem_req high until imem_ready, IR load
// DECODE | opcode latched into r_op
// EXEC   | ALU op, branch/jump resolution, EOE detect
// MEM    | LW/SW held until dmem_ready
// WB     | regfile write plus PC advance
// HALT   | EOE retired, sticky until rst
// FAULT  | handshake timeout, sticky until rst
module ctrl_fsm
   import cpu_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   ctrl_fsm_if.slave   bus
);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_op;

   logic       w_imem_req, w_ir_load, w_pc_we, w_reg_we;
   logic       w_dmem_re, w_dmem_we, w_halted, w_fault;
   logic [1:0] w_pc_sel, w_wb_sel;
   logic [3:0] w_alu_op;
   logic       w_timeout, w_wait_en, w_ready, w_clr, w_is_eoe;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_op    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_DECODE) r_op <= bus.opcode;
      end
   end

   assign w_wait_en = (r_state == ST_FETCH) || (r_state == ST_MEM);
   assign w_ready   = (r_state == ST_FETCH) ? bus.imem_ready : bus.dmem_ready;
   // FETCH and MEM only self-loop while waiting, so any state change is an entry
   assign w_clr     = (w_state_nxt != r_state);
   assign w_is_eoe  = (bus.func == FUNC_EOE);

   ctrl_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (w_clr),
      .i_en      (w_wait_en),
      .i_ready   (w_ready),
      .o_timeout (w_timeout)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_imem_req  = 1'b0;
      w_ir_load   = 1'b0;
      w_pc_we     = 1'b0;
      w_pc_sel    = PC_SEL_INC;
      w_alu_op    = OP_ADD;
      w_reg_we    = 1'b0;
      w_wb_sel    = WB_SEL_ALU;
      w_dmem_re   = 1'b0;
      w_dmem_we   = 1'b0;
      w_halted    = 1'b0;
      w_fault     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) w_state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            w_imem_req = 1'b1;
            if (bus.imem_ready) begin
               w_ir_load   = 1'b1;
               w_state_nxt = ST_DECODE;
            end else if (w_timeout) begin
               w_state_nxt = ST_FAULT;
            end
         end
         ST_DECODE: begin
            w_state_nxt = (bus.opcode == OP_LI) ? ST_WB : ST_EXEC;
         end
         ST_EXEC: begin
            w_alu_op = is_alu_op(r_op) ? r_op : OP_ADD;
            case (r_op)
               OP_LW, OP_SW: w_state_nxt = ST_MEM;
               OP_BIZ: begin
                  w_pc_we     = 1'b1;
                  w_pc_sel    = bus.zero ? PC_SEL_IMM : PC_SEL_INC;
                  w_state_nxt = ST_FETCH;
               end
               OP_BNZ: begin
                  w_pc_we     = 1'b1;
                  w_pc_sel    = bus.zero ? PC_SEL_INC : PC_SEL_IMM;
                  w_state_nxt = ST_FETCH;
               end
               OP_JMP: begin
                  w_pc_we     = 1'b1;
                  w_pc_sel    = PC_SEL_IMM;
                  w_state_nxt = ST_FETCH;
               end
               OP_JR: begin
                  if (w_is_eoe) begin
                     w_state_nxt = ST_HALT;
                  end else begin
                     w_pc_we     = 1'b1;
                     w_pc_sel    = PC_SEL_REG;
                     w_state_nxt = ST_FETCH;
                  end
               end
               default: w_state_nxt = ST_WB;
            endcase
         end
         ST_MEM: begin
            w_dmem_re = (r_op == OP_LW);
            w_dmem_we = (r_op != OP_LW);
            if (bus.dmem_ready) begin
               if (r_op == OP_LW) begin
                  w_state_nxt = ST_WB;
               end else begin
                  w_pc_we     = 1'b1;
                  w_state_nxt = ST_FETCH;
               end
            end else if (w_timeout) begin
               w_state_nxt = ST_FAULT;
            end
         end
         ST_WB: begin
            w_reg_we    = 1'b1;
            w_pc_we     = 1'b1;
            w_state_nxt = ST_FETCH;
            case (r_op)
               OP_LI:  w_wb_sel = WB_SEL_IMM;
               OP_LW:  w_wb_sel = WB_SEL_MEM;
               OP_JAL: begin
                  w_wb_sel = WB_SEL_PC1;
                  w_pc_sel = PC_SEL_IMM;
               end
               default: w_wb_sel = WB_SEL_ALU;
            endcase
         end
         ST_HALT:  w_halted = 1'b1;
         ST_FAULT: w_fault  = 1'b1;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   assign bus.imem_req = w_imem_req;
   assign bus.ir_load  = w_ir_load;
   assign bus.pc_we    = w_pc_we;
   assign bus.pc_sel   = w_pc_sel;
   assign bus.alu_op   = w_alu_op;
   assign bus.reg_we   = w_reg_we;
   assign bus.wb_sel   = w_wb_sel;
   assign bus.dmem_re  = w_dmem_re;
   assign bus.dmem_we  = w_dmem_we;
   assign bus.halted   = w_halted;
   assign bus.fault    = w_fault;
   assign bus.state    = r_state;

`ifdef CTRL_PERF_EN
   logic [15:0] r_retired;
   logic [15:0] r_cycles;
   logic        w_retire, w_active;

   assign w_retire = ((w_state_nxt == ST_FETCH) &&
                      (r_state == ST_EXEC || r_state == ST_MEM || r_state == ST_WB)) ||
                     ((w_state_nxt == ST_HALT) && (r_state != ST_HALT));
   // counting starts with the cycle that accepts start
   assign w_active = ((r_state != ST_IDLE) && (r_state != ST_HALT) && (r_state != ST_FAULT)) ||
                     ((r_state == ST_IDLE) && bus.start);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_retired <= '0;
         r_cycles  <= '0;
      end else begin
         if (w_retire) r_retired <= r_retired + 16'd1;
         if (w_active) r_cycles  <= r_cycles + 16'd1;
      end
   end

   assign bus.retired = r_retired;
   assign bus.cycles  = r_cycles;
`endif

endmodule
